// File: rtl/rx_word_align_ctrl.sv
// Word-alignment trainer for an ISERDES/IDELAY lane. It steps bitslips within each delay tap and steps taps, until it sees the training word.
// Optional link monitor in DONE: define RX_ALIGN_MONITOR_EN to add train_active/lost_lock.
module rx_word_align_ctrl #(
   parameter int                    DATA_WIDTH    = 12,
   parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 12'hF00,
   parameter int                    SETTLE_CYC    = 16,
   parameter int                    MATCH_CNT     = 64,
   parameter int                    MAX_TAP       = 31
) (
   input  logic                  rx_clkdiv6,
   input  logic                  rx_reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] rx_data,
`ifdef RX_ALIGN_MONITOR_EN
   input  logic                  train_active,
   output logic                  lost_lock,
`endif
   output logic                  bitslip,
   output logic                  dly_ld,
   output logic                  dly_ce,
   output logic                  dly_inc,
   output logic [4:0]            dly_tap,
   output logic [3:0]            slip_cnt,
   output logic                  busy,
   output logic                  aligned,
   output logic                  align_fail
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam int MW = $clog2(MATCH_CNT + 1);

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, SLIP, INC_TAP, DONE, FAIL} state_t;

   state_t          state, next;
   logic [SW-1:0]   settle_cnt;
   logic [MW-1:0]   match_cnt;
   logic [4:0]      tap_q;
   logic [3:0]      slip_q;
   logic            match;
   logic            lost_c;

   assign match = (rx_data == TRAIN_PATTERN);

`ifdef RX_ALIGN_MONITOR_EN
   logic [1:0] mon_cnt;
   logic       lost_q;

   assign lost_c = (state == DONE) && train_active && !match && (mon_cnt == 2'd3);

   always_ff @(posedge rx_clkdiv6) begin
      if (rx_reset) begin
         mon_cnt <= '0;
         lost_q  <= 1'b0;
      end else begin
         lost_q <= lost_c;
         if (state != DONE || lost_c)
            mon_cnt <= '0;
         else if (train_active)
            mon_cnt <= match ? 2'd0 : mon_cnt + 2'd1;
      end
   end

   assign lost_lock = lost_q & ~rx_reset;
`else
   assign lost_c = 1'b0;
`endif

   always_comb begin
      next = state;
      case (state)
         IDLE:    next = IDLE;
         LOAD:    next = SETTLE;
         SETTLE:  if (settle_cnt == SW'(SETTLE_CYC - 1)) next = CHECK;
         CHECK: begin
            if (match) begin
               if (match_cnt == MW'(MATCH_CNT - 1)) next = DONE;
            end else if (slip_q < 4'(DATA_WIDTH - 1)) begin
               next = SLIP;
            end else if (tap_q == 5'(MAX_TAP)) begin
               next = FAIL;
            end else begin
               next = INC_TAP;
            end
         end
         SLIP:    next = SETTLE;
         INC_TAP: next = SETTLE;
         DONE:    if (lost_c) next = LOAD;
         FAIL:    next = FAIL;
         default: next = IDLE;
      endcase
      // start restarts training from any state, including a search in progress
      if (start) next = LOAD;
   end

   always_ff @(posedge rx_clkdiv6) begin
      if (rx_reset) begin
         state      <= IDLE;
         settle_cnt <= '0;
         match_cnt  <= '0;
         tap_q      <= '0;
         slip_q     <= '0;
      end else begin
         state      <= next;
         settle_cnt <= (state == SETTLE && next == SETTLE) ? settle_cnt + 1'b1 : '0;
         match_cnt  <= (state == CHECK && next == CHECK && match) ? match_cnt + 1'b1 : '0;
         if (next == LOAD) begin
            tap_q  <= '0;
            slip_q <= '0;
         end else if (state == SLIP) begin
            slip_q <= slip_q + 4'd1;
         end else if (state == INC_TAP) begin
            tap_q  <= tap_q + 5'd1;
            slip_q <= '0;
         end
      end
   end

   // Gating with rx_reset kills a pulse in the very cycle reset is raised.
   assign bitslip    = (state == SLIP)    & ~rx_reset;
   assign dly_ld     = (state == LOAD)    & ~rx_reset;
   assign dly_ce     = (state == INC_TAP) & ~rx_reset;
   assign dly_inc    = (state == INC_TAP) & ~rx_reset;
   assign dly_tap    = rx_reset ? 5'd0 : tap_q;
   assign slip_cnt   = rx_reset ? 4'd0 : slip_q;
   assign busy       = (state != IDLE) && (state != DONE) && (state != FAIL) && !rx_reset;
   assign aligned    = (state == DONE) & ~rx_reset;
   assign align_fail = (state == FAIL) & ~rx_reset;

endmodule
